rs_alu: RTL
===========

Name: rs_alu

Overview:
- Reservation station for the integer ALU. It holds dispatched ALU/branch/jump ops until their source operands are available.
- It snoops the ALU and LSB result broadcast buses (CDB) for pending operand tags.
- Each cycle it issues at most one ready entry to the ALU.
- Sits between decoder/dispatch (upstream) and the ALU (downstream).

Parameters:
- RS_SIZE, 16, number of entries (power of 2).
- ROB_W, 4, ROB index width.
- OP_W, 6, internal opcode width.
- XLEN, 32, data/imm/pc width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ready  in  1  global enable; low = freeze all state and outputs
- clear  in  1  flush on mispredict; drops all entries
- disp_en  in  1  dispatch valid
- disp_op  in  OP_W  opcode
- disp_imm  in  XLEN  immediate
- disp_pc  in  XLEN  instruction pc
- disp_robpos  in  ROB_W  destination ROB index
- disp_qj_busy  in  1  rs1 pending
- disp_qj  in  ROB_W  rs1 producer tag
- disp_vj  in  XLEN  rs1 value (valid when not pending)
- disp_qk_busy  in  1  rs2 pending
- disp_qk  in  ROB_W  rs2 producer tag
- disp_vk  in  XLEN  rs2 value
- alu_flag, alu_val, alu_robpos  in  1/XLEN/ROB_W  ALU broadcast
- lsb_flag, lsb_val, lsb_robpos  in  1/XLEN/ROB_W  LSB broadcast
- rs_full  out  1  combinational; no free entry
- work  out  1  registered issue valid to ALU
- op, imm, pc  out  OP_W/XLEN/XLEN  issued fields
- robpos  out  ROB_W  issued ROB index
- rs1, rs2  out  XLEN  issued operand values

Behaviour:
- Reset: all busy bits 0; work=0; op, imm, pc, robpos, rs1, rs2 = 0.
- Clear: all busy bits 0; work=0 next edge. Clear has priority over dispatch, issue and wakeup in that cycle.
- ready low: no state change at all. A dispatch or broadcast presented in that cycle is ignored; the upstream holds it.
- Dispatch (disp_en and free entry): write into the lowest-index free entry and set busy.
- Dispatch with rs_full=1: ignored; the upstream must not do this.
- Dispatch-time capture: if disp_qj_busy and a same-cycle broadcast tag equals disp_qj, store the broadcast value and mark the operand ready. Same rule for k.
- Wakeup: every busy entry with a pending operand whose tag matches alu_robpos (when alu_flag) or lsb_robpos (when lsb_flag) captures the value and clears the pending bit.
  - Both buses match the same tag: take the ALU value (cannot occur legally).
- Issue: select the lowest-index entry with busy=1 and both operands ready, using state before this edge.
  - Next edge: work=1, outputs loaded from that entry, entry busy cleared.
  - No candidate: work=0; other outputs hold.
- Latency: an entry dispatched at edge N with ready operands issues at edge N+1 at the earliest. A wakeup at edge N allows issue at edge N+1. There is no same-cycle wakeup-to-issue.
- An entry freed by issue at edge N is free for dispatch from edge N+1. rs_full is computed from the busy bits only.
- Exactly one issue per cycle max. Dispatch and issue in the same cycle both occur.
- Ops without rs1/rs2 (LUI, AUIPC, JAL): the dispatcher drives the busy flags 0. The values are don't-care.

Optional Feature:
- Macro: RS_PERF_CNT_EN.
- When defined: adds outputs issue_cnt (32) and full_cnt (32).
  - issue_cnt increments on each issue.
  - full_cnt increments each ready cycle with rs_full=1.
  - Both reset to 0 on reset only; clear does not affect them. They freeze when ready=0.
- When undefined: the ports and counters do not exist.

Decomposition:
- Shared def package holds OP_LEN, ROB_LEN, DATA_LEN, IMM_LEN, PC_LEN widths and the opcode encodings shared with decoder and ALU.
- One natural sub-module, rs_prio_enc: parameterised lowest-index-set-bit encoder with a found flag. It is instantiated twice, for the free-slot pick and the issue pick.

Test Plan:
- Dispatch ADDI, robpos=3, vj=5, imm=7, both ready -> next edge work=1, op=ADDI, robpos=3, rs1=5, imm=7; entry 0 freed.
- Dispatch ADD with qj=2 pending, vk=10; after 3 idle cycles alu_flag=1, alu_robpos=2, alu_val=20 -> work=0 until the wakeup edge, work=1 the edge after with rs1=20, rs2=10.
- Dispatch with qj=6 pending while the same cycle has lsb_flag=1, lsb_robpos=6, lsb_val=0xFFFFFFFF -> entry captures it and issues next edge with rs1=0xFFFFFFFF.
- Fill 16 entries all pending on tag 9 -> rs_full=1; a 17th dispatch is ignored. Broadcast tag 9 -> entries issue in index order 0..15, one per cycle, and rs_full drops after the first issue.
- 4 entries busy, assert clear with a simultaneous dispatch -> all busy=0, work=0, rs_full=0; the dispatched op is dropped.
- Ready entry present, hold ready=0 for 5 cycles with a broadcast -> no issue, no capture, outputs unchanged. Issue occurs the first edge after ready=1.

Source files
------------

// File: rtl/rs_alu_pkg.sv
// rs_alu_pkg: shared widths and opcode encodings used by decoder, reservation
// station and ALU.
//   OP_LEN   internal opcode width
//   ROB_LEN  ROB index width
//   DATA_LEN / IMM_LEN / PC_LEN  datapath, immediate and pc widths
//   alu_op_e internal opcode encodings
package rs_alu_pkg;

  localparam int unsigned OP_LEN   = 6;
  localparam int unsigned ROB_LEN  = 4;
  localparam int unsigned DATA_LEN = 32;
  localparam int unsigned IMM_LEN  = 32;
  localparam int unsigned PC_LEN   = 32;

  typedef enum logic [OP_LEN-1:0] {
    OP_NOP   = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND
  } alu_op_e;

endpackage

// File: rtl/rs_alu_if.sv
// rs_alu_if: dispatch, CDB snoop and ALU issue bundle of the ALU reservation
// station.
//   master: dispatch/broadcast driver side (drives disp_*, alu_*, lsb_*)
//   slave : reservation station side (drives rs_full and the issue fields)
interface rs_alu_if
  import rs_alu_pkg::*;
#(
  parameter int unsigned ROB_W = ROB_LEN,
  parameter int unsigned OP_W  = OP_LEN,
  parameter int unsigned XLEN  = DATA_LEN
) ();

  // dispatch
  logic             disp_en;
  logic [OP_W-1:0]  disp_op;
  logic [XLEN-1:0]  disp_imm;
  logic [XLEN-1:0]  disp_pc;
  logic [ROB_W-1:0] disp_robpos;
  logic             disp_qj_busy;
  logic [ROB_W-1:0] disp_qj;
  logic [XLEN-1:0]  disp_vj;
  logic             disp_qk_busy;
  logic [ROB_W-1:0] disp_qk;
  logic [XLEN-1:0]  disp_vk;
  // result broadcasts
  logic             alu_flag;
  logic [XLEN-1:0]  alu_val;
  logic [ROB_W-1:0] alu_robpos;
  logic             lsb_flag;
  logic [XLEN-1:0]  lsb_val;
  logic [ROB_W-1:0] lsb_robpos;
  // status and issue
  logic             rs_full;
  logic             work;
  logic [OP_W-1:0]  op;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  pc;
  logic [ROB_W-1:0] robpos;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;

  modport master (
    output disp_en, disp_op, disp_imm, disp_pc, disp_robpos,
           disp_qj_busy, disp_qj, disp_vj, disp_qk_busy, disp_qk, disp_vk,
           alu_flag, alu_val, alu_robpos, lsb_flag, lsb_val, lsb_robpos,
    input  rs_full, work, op, imm, pc, robpos, rs1, rs2
  );

  modport slave (
    input  disp_en, disp_op, disp_imm, disp_pc, disp_robpos,
           disp_qj_busy, disp_qj, disp_vj, disp_qk_busy, disp_qk, disp_vk,
           alu_flag, alu_val, alu_robpos, lsb_flag, lsb_val, lsb_robpos,
    output rs_full, work, op, imm, pc, robpos, rs1, rs2
  );

endinterface

// File: rtl/rs_prio_enc.sv
// rs_prio_enc: lowest-index set-bit encoder.
//   req_i   request vector
//   idx_o   index of the lowest set bit (0 when none)
//   found_o at least one bit set
module rs_prio_enc #(
  parameter int unsigned N = 16,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && !found_o) begin
        idx_o   = W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_alu.sv
// rs_alu: reservation station for the integer ALU. Holds dispatched ops until
// both operands are available (snooping the ALU and LSB broadcast buses) and
// issues at most one ready entry per cycle, lowest index first.
//   clk, reset  clock, synchronous active-high reset
//   ready       global enable; low freezes all state and outputs
//   clear       mispredict flush; drops every entry
//   bus         rs_alu_if slave: dispatch, broadcasts, rs_full, issue fields
// Optional: define RS_PERF_CNT_EN to add issue_cnt / full_cnt counters.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int unsigned RS_SIZE = 16,
  parameter int unsigned ROB_W   = ROB_LEN,
  parameter int unsigned OP_W    = OP_LEN,
  parameter int unsigned XLEN    = DATA_LEN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic        clear,
  rs_alu_if.slave     bus
`ifdef RS_PERF_CNT_EN
  ,
  output logic [31:0] issue_cnt,
  output logic [31:0] full_cnt
`endif
);

  localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  // entry state
  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] qjb_q, qjb_d, qkb_q, qkb_d;
  logic [OP_W-1:0]    op_q  [RS_SIZE], op_d  [RS_SIZE];
  logic [XLEN-1:0]    imm_q [RS_SIZE], imm_d [RS_SIZE];
  logic [XLEN-1:0]    pc_q  [RS_SIZE], pc_d  [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE], rob_d [RS_SIZE];
  logic [ROB_W-1:0]   qj_q  [RS_SIZE], qj_d  [RS_SIZE];
  logic [ROB_W-1:0]   qk_q  [RS_SIZE], qk_d  [RS_SIZE];
  logic [XLEN-1:0]    vj_q  [RS_SIZE], vj_d  [RS_SIZE];
  logic [XLEN-1:0]    vk_q  [RS_SIZE], vk_d  [RS_SIZE];

  // issue output registers
  logic               work_q, work_d;
  logic [OP_W-1:0]    iss_op_q, iss_op_d;
  logic [XLEN-1:0]    iss_imm_q, iss_imm_d;
  logic [XLEN-1:0]    iss_pc_q, iss_pc_d;
  logic [ROB_W-1:0]   iss_rob_q, iss_rob_d;
  logic [XLEN-1:0]    iss_rs1_q, iss_rs1_d;
  logic [XLEN-1:0]    iss_rs2_q, iss_rs2_d;

  logic [RS_SIZE-1:0] free_vec, rdy_vec;
  logic [IDX_W-1:0]   free_idx, iss_idx;
  logic               free_found, iss_found;

  assign free_vec = ~busy_q;
  assign rdy_vec  = busy_q & ~qjb_q & ~qkb_q;

  rs_prio_enc #(.N(RS_SIZE), .W(IDX_W)) u_free_pick (
    .req_i   (free_vec),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  rs_prio_enc #(.N(RS_SIZE), .W(IDX_W)) u_issue_pick (
    .req_i   (rdy_vec),
    .idx_o   (iss_idx),
    .found_o (iss_found)
  );

  always_comb begin
    busy_d    = busy_q;
    qjb_d     = qjb_q;
    qkb_d     = qkb_q;
    op_d      = op_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    rob_d     = rob_q;
    qj_d      = qj_q;
    qk_d      = qk_q;
    vj_d      = vj_q;
    vk_d      = vk_q;
    work_d    = work_q;
    iss_op_d  = iss_op_q;
    iss_imm_d = iss_imm_q;
    iss_pc_d  = iss_pc_q;
    iss_rob_d = iss_rob_q;
    iss_rs1_d = iss_rs1_q;
    iss_rs2_d = iss_rs2_q;

    if (ready) begin
      if (clear) begin
        busy_d = '0;
        work_d = 1'b0;
      end else begin
        // wakeup; ALU bus wins if both buses carry the same tag
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && qjb_q[i]) begin
            if (bus.alu_flag && bus.alu_robpos == qj_q[i]) begin
              vj_d[i]  = bus.alu_val;
              qjb_d[i] = 1'b0;
            end else if (bus.lsb_flag && bus.lsb_robpos == qj_q[i]) begin
              vj_d[i]  = bus.lsb_val;
              qjb_d[i] = 1'b0;
            end
          end
          if (busy_q[i] && qkb_q[i]) begin
            if (bus.alu_flag && bus.alu_robpos == qk_q[i]) begin
              vk_d[i]  = bus.alu_val;
              qkb_d[i] = 1'b0;
            end else if (bus.lsb_flag && bus.lsb_robpos == qk_q[i]) begin
              vk_d[i]  = bus.lsb_val;
              qkb_d[i] = 1'b0;
            end
          end
        end

        // issue from pre-edge state, so a wakeup this cycle issues next cycle
        work_d = iss_found;
        if (iss_found) begin
          busy_d[iss_idx] = 1'b0;
          iss_op_d        = op_q[iss_idx];
          iss_imm_d       = imm_q[iss_idx];
          iss_pc_d        = pc_q[iss_idx];
          iss_rob_d       = rob_q[iss_idx];
          iss_rs1_d       = vj_q[iss_idx];
          iss_rs2_d       = vk_q[iss_idx];
        end

        // dispatch into a free slot; never the slot being issued
        if (bus.disp_en && free_found) begin
          busy_d[free_idx] = 1'b1;
          op_d[free_idx]   = bus.disp_op;
          imm_d[free_idx]  = bus.disp_imm;
          pc_d[free_idx]   = bus.disp_pc;
          rob_d[free_idx]  = bus.disp_robpos;
          qj_d[free_idx]   = bus.disp_qj;
          qk_d[free_idx]   = bus.disp_qk;
          qjb_d[free_idx]  = bus.disp_qj_busy;
          vj_d[free_idx]   = bus.disp_vj;
          qkb_d[free_idx]  = bus.disp_qk_busy;
          vk_d[free_idx]   = bus.disp_vk;
          if (bus.disp_qj_busy) begin
            if (bus.alu_flag && bus.alu_robpos == bus.disp_qj) begin
              vj_d[free_idx]  = bus.alu_val;
              qjb_d[free_idx] = 1'b0;
            end else if (bus.lsb_flag && bus.lsb_robpos == bus.disp_qj) begin
              vj_d[free_idx]  = bus.lsb_val;
              qjb_d[free_idx] = 1'b0;
            end
          end
          if (bus.disp_qk_busy) begin
            if (bus.alu_flag && bus.alu_robpos == bus.disp_qk) begin
              vk_d[free_idx]  = bus.alu_val;
              qkb_d[free_idx] = 1'b0;
            end else if (bus.lsb_flag && bus.lsb_robpos == bus.disp_qk) begin
              vk_d[free_idx]  = bus.lsb_val;
              qkb_d[free_idx] = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= '0;
      qjb_q     <= '0;
      qkb_q     <= '0;
      work_q    <= 1'b0;
      iss_op_q  <= '0;
      iss_imm_q <= '0;
      iss_pc_q  <= '0;
      iss_rob_q <= '0;
      iss_rs1_q <= '0;
      iss_rs2_q <= '0;
    end else begin
      busy_q    <= busy_d;
      qjb_q     <= qjb_d;
      qkb_q     <= qkb_d;
      work_q    <= work_d;
      iss_op_q  <= iss_op_d;
      iss_imm_q <= iss_imm_d;
      iss_pc_q  <= iss_pc_d;
      iss_rob_q <= iss_rob_d;
      iss_rs1_q <= iss_rs1_d;
      iss_rs2_q <= iss_rs2_d;
    end
  end

  // payload is qualified by busy, so it needs no reset
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    imm_q <= imm_d;
    pc_q  <= pc_d;
    rob_q <= rob_d;
    qj_q  <= qj_d;
    qk_q  <= qk_d;
    vj_q  <= vj_d;
    vk_q  <= vk_d;
  end

  assign bus.rs_full = ~free_found;
  assign bus.work    = work_q;
  assign bus.op      = iss_op_q;
  assign bus.imm     = iss_imm_q;
  assign bus.pc      = iss_pc_q;
  assign bus.robpos  = iss_rob_q;
  assign bus.rs1     = iss_rs1_q;
  assign bus.rs2     = iss_rs2_q;

`ifdef RS_PERF_CNT_EN
  logic [31:0] issue_cnt_q, full_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt_q <= '0;
      full_cnt_q  <= '0;
    end else if (ready) begin
      if (!clear && iss_found) issue_cnt_q <= issue_cnt_q + 32'd1;
      if (!free_found)         full_cnt_q  <= full_cnt_q + 32'd1;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign full_cnt  = full_cnt_q;
`endif

endmodule
